// File: rtl/operand_fetch.sv
// operand_fetch: drives the regfile read ports, forwards writeback data and holds operands for execute.
// Latency: accept in cycle N presents operands in cycle N+1; 1 instruction/cycle while out_ready is high.
// Backpressure: in_ready = empty || out_ready; held operands stay stable. OPFETCH_PERF_EN adds perf_stall_cnt.
module operand_fetch #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [4:0]           rf_r1_reg_name,
    input  logic [XLEN-1:0]      rf_r1_reg_val,
    output logic [4:0]           rf_r2_reg_name,
    input  logic [XLEN-1:0]      rf_r2_reg_val,
    input  logic                 wb_enable,
    input  logic [4:0]           wb_reg_name,
    input  logic [XLEN-1:0]      wb_reg_val,
    output logic                 rf_w_enable,
    output logic [4:0]           rf_w_reg_name,
    output logic [XLEN-1:0]      rf_w_reg_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [PAYLOAD_W-1:0] out_payload
`ifdef OPFETCH_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RF    = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [PAYLOAD_W-1:0] payload;
    } inst_t;

    state_t          r_state;
    inst_t           r_inst;
    logic            r_byp_hit1;
    logic            r_byp_hit2;
    logic [XLEN-1:0] r_byp_val1;
    logic [XLEN-1:0] r_byp_val2;
    logic [XLEN-1:0] r_hold_val1;
    logic [XLEN-1:0] r_hold_val2;

    logic            w_accept;
    logic            w_issue_hit1;
    logic            w_issue_hit2;
    logic            w_stall;
    logic [XLEN-1:0] w_res1;
    logic [XLEN-1:0] w_res2;

    // Priority: x0, live writeback, then the source selected by the current state.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input state_t          st,
        input logic            byp_hit,
        input logic [XLEN-1:0] byp_val,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] hold_val,
        input logic            wb_en,
        input logic [4:0]      wb_name,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (rs == 5'd0) begin
            v = '0;
        end else if (wb_en && (wb_name == rs)) begin
            v = wb_val;
        end else if (st == S_RF) begin
            v = byp_hit ? byp_val : rf_val;
        end else if (st == S_HOLD) begin
            v = hold_val;
        end
        return v;
    endfunction

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = (r_state == S_EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready && !rst;
    assign w_stall   = out_valid && !out_ready;

    assign rf_r1_reg_name = w_accept ? in_rs1 : r_inst.rs1;
    assign rf_r2_reg_name = w_accept ? in_rs2 : r_inst.rs2;

    // The regfile read issued on the accept edge sees the pre-write value, so catch that write here.
    assign w_issue_hit1 = wb_enable && (wb_reg_name == in_rs1) && (in_rs1 != 5'd0);
    assign w_issue_hit2 = wb_enable && (wb_reg_name == in_rs2) && (in_rs2 != 5'd0);

    assign w_res1 = resolve(r_inst.rs1, r_state, r_byp_hit1, r_byp_val1, rf_r1_reg_val,
                            r_hold_val1, wb_enable, wb_reg_name, wb_reg_val);
    assign w_res2 = resolve(r_inst.rs2, r_state, r_byp_hit2, r_byp_val2, rf_r2_reg_val,
                            r_hold_val2, wb_enable, wb_reg_name, wb_reg_val);

    assign out_rs1_val = w_res1;
    assign out_rs2_val = w_res2;
    assign out_payload = r_inst.payload;

    assign rf_w_enable   = wb_enable;
    assign rf_w_reg_name = wb_reg_name;
    assign rf_w_reg_val  = wb_reg_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_inst      <= '0;
            r_byp_hit1  <= 1'b0;
            r_byp_hit2  <= 1'b0;
            r_byp_val1  <= '0;
            r_byp_val2  <= '0;
            r_hold_val1 <= '0;
            r_hold_val2 <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_RF;
                    end
                end
                default: begin
                    if (!out_ready) begin
                        r_state <= S_HOLD;
                    end else if (w_accept) begin
                        r_state <= S_RF;
                    end else begin
                        r_state <= S_EMPTY;
                    end
                end
            endcase

            if (w_accept) begin
                r_inst.rs1     <= in_rs1;
                r_inst.rs2     <= in_rs2;
                r_inst.payload <= in_payload;
                r_byp_hit1     <= w_issue_hit1;
                r_byp_hit2     <= w_issue_hit2;
                if (w_issue_hit1) begin
                    r_byp_val1 <= wb_reg_val;
                end
                if (w_issue_hit2) begin
                    r_byp_val2 <= wb_reg_val;
                end
            end

            // Covers both the RF->HOLD capture and live writeback updates while held.
            if (w_stall) begin
                r_hold_val1 <= w_res1;
                r_hold_val2 <= w_res2;
            end
        end
    end

`ifdef OPFETCH_PERF_EN
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
        end else if (w_stall) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: regfile model, scoreboard of expected operands, vector table plus corner sequences.
module tb_operand_fetch;
    localparam int XLEN = 32;
    localparam int PW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [PW-1:0]   in_payload;
    logic [4:0]      rf_r1_reg_name;
    logic [XLEN-1:0] rf_r1_reg_val;
    logic [4:0]      rf_r2_reg_name;
    logic [XLEN-1:0] rf_r2_reg_val;
    logic            wb_enable;
    logic [4:0]      wb_reg_name;
    logic [XLEN-1:0] wb_reg_val;
    logic            rf_w_enable;
    logic [4:0]      rf_w_reg_name;
    logic [XLEN-1:0] rf_w_reg_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [PW-1:0]   out_payload;
`ifdef OPFETCH_PERF_EN
    logic [31:0]     perf_stall_cnt;
`endif

    operand_fetch #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_payload(in_payload),
        .rf_r1_reg_name(rf_r1_reg_name), .rf_r1_reg_val(rf_r1_reg_val),
        .rf_r2_reg_name(rf_r2_reg_name), .rf_r2_reg_val(rf_r2_reg_val),
        .wb_enable(wb_enable), .wb_reg_name(wb_reg_name), .wb_reg_val(wb_reg_val),
        .rf_w_enable(rf_w_enable), .rf_w_reg_name(rf_w_reg_name), .rf_w_reg_val(rf_w_reg_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_payload(out_payload)
`ifdef OPFETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Regfile with registered reads; a write and a read of the same edge returns the old value.
    bit [XLEN-1:0] mem [32];
    always @(posedge clk) begin
        rf_r1_reg_val <= mem[rf_r1_reg_name];
        rf_r2_reg_val <= mem[rf_r2_reg_name];
        if (rf_w_enable && rf_w_reg_name != 5'd0) mem[rf_w_reg_name] <= rf_w_reg_val;
    end

    typedef struct {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic [PW-1:0]   pl;
    } exp_t;

    typedef struct {
        logic            iv;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            we;
        logic [4:0]      wn;
        logic [XLEN-1:0] wv;
        logic            ordy;
        logic            acc;
        logic            ov;
    } vec_t;

    exp_t          sb[$];
    exp_t          head;
    bit [XLEN-1:0] ref_rf [32];
    int            checks = 0;
    int            errors = 0;
    int            n_out  = 0;
    int            n_acc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every presented cycle is compared; a live writeback to the head's sources becomes its new value.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_out actual=valid required=idle");
            end else begin
                head = sb[0];
                if (wb_enable && wb_reg_name != 5'd0) begin
                    if (wb_reg_name == head.rs1) head.v1 = wb_reg_val;
                    if (wb_reg_name == head.rs2) head.v2 = wb_reg_val;
                end
                sb[0] = head;
                chk("sb_rs1", 64'(out_rs1_val), 64'(head.v1));
                chk("sb_rs2", 64'(out_rs2_val), 64'(head.v2));
                chk("sb_payload", 64'(out_payload), 64'(head.pl));
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic cyc(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [PW-1:0] pl, input logic we, input logic [4:0] wn,
                       input logic [XLEN-1:0] wv, input logic ordy, output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_payload = pl;
        wb_enable = we; wb_reg_name = wn; wb_reg_val = wv; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (we && wn != 5'd0) ref_rf[wn] = wv;
        chk("rf_w_enable", 64'(rf_w_enable), 64'(we));
        chk("rf_w_reg_name", 64'(rf_w_reg_name), 64'(wn));
        chk("rf_w_reg_val", 64'(rf_w_reg_val), 64'(wv));
        if (acc) begin
            e.rs1 = r1; e.rs2 = r2; e.pl = pl;
            e.v1 = (r1 == 5'd0) ? '0 : ref_rf[r1];
            e.v2 = (r2 == 5'd0) ? '0 : ref_rf[r2];
            sb.push_back(e);
            n_acc++;
            chk("rf_r1_reg_name", 64'(rf_r1_reg_name), 64'(r1));
            chk("rf_r2_reg_name", 64'(rf_r2_reg_name), 64'(r2));
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        cyc(1'b0, 5'd0, 5'd0, '0, 1'b0, 5'd0, '0, ordy, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd7; wb_enable = 1'b0; out_ready = 1'b0;
        n_acc -= sb.size();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
    endtask

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        tbl[0]  = '{1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h101,  1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd3, 5'd1, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 5'd3, 5'd1, 1'b1, 5'd2, 32'h202,  1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 5'd3, 5'd1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 5'd2, 5'd2, 1'b1, 5'd2, 32'h2F2,  1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h303,  1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 5'd3, 5'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h333,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 5'd4, 5'd3, 1'b1, 5'd4, 32'h404,  1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_payload = '0;
        wb_enable = 1'b0; wb_reg_name = 5'd0; wb_reg_val = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rs1", 64'(out_rs1_val), 64'd0);
        chk("rst_rs2", 64'(out_rs2_val), 64'd0);
        chk("rst_payload", 64'(out_payload), 64'd0);
        chk("rst_rf_r1_name", 64'(rf_r1_reg_name), 64'd0);
`ifdef OPFETCH_PERF_EN
        chk("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif

        // Preload x5 / x6 through the writeback pass-through.
        cyc(1'b0, 5'd0, 5'd0, '0, 1'b1, 5'd5, 32'h11, 1'b1, acc);
        cyc(1'b0, 5'd0, 5'd0, '0, 1'b1, 5'd6, 32'h22, 1'b1, acc);

        // Plain read, one-cycle latency.
        cyc(1'b1, 5'd5, 5'd6, 32'hA001, 1'b0, 5'd0, '0, 1'b1, acc);
        chk("t1_acc", 64'(acc), 64'd1);
        idle(1'b1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_rs1", 64'(out_rs1_val), 64'h11);
        chk("t1_rs2", 64'(out_rs2_val), 64'h22);
        chk("t1_payload", 64'(out_payload), 64'hA001);

        // Writeback in the issue cycle must win over the stale regfile read.
        cyc(1'b1, 5'd5, 5'd6, 32'hA002, 1'b1, 5'd5, 32'hAA, 1'b1, acc);
        idle(1'b1);
        chk("t2_rs1_bypass", 64'(out_rs1_val), 64'hAA);
        chk("t2_rs2", 64'(out_rs2_val), 64'h22);

        // x0 never forwards.
        cyc(1'b1, 5'd0, 5'd6, 32'hA003, 1'b1, 5'd0, 32'hFF, 1'b1, acc);
        cyc(1'b0, 5'd0, 5'd0, '0, 1'b1, 5'd0, 32'hFF, 1'b1, acc);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_rs1_x0", 64'(out_rs1_val), 64'd0);
        idle(1'b1);

        // Three-cycle stall, writeback to x6 in the second stall cycle, then transfer with a new accept.
        cyc(1'b1, 5'd5, 5'd6, 32'hA004, 1'b0, 5'd0, '0, 1'b1, acc);
        cyc(1'b1, 5'd1, 5'd1, 32'hBAD0, 1'b0, 5'd0, '0, 1'b0, acc);
        chk("t4_s1_acc", 64'(acc), 64'd0);
        chk("t4_s1_in_ready", 64'(in_ready), 64'd0);
        chk("t4_s1_rs2", 64'(out_rs2_val), 64'h22);
        cyc(1'b1, 5'd1, 5'd1, 32'hBAD1, 1'b1, 5'd6, 32'h77, 1'b0, acc);
        chk("t4_s2_in_ready", 64'(in_ready), 64'd0);
        chk("t4_s2_rs2", 64'(out_rs2_val), 64'h77);
        cyc(1'b1, 5'd1, 5'd1, 32'hBAD2, 1'b0, 5'd0, '0, 1'b0, acc);
        chk("t4_s3_in_ready", 64'(in_ready), 64'd0);
        chk("t4_s3_rs2", 64'(out_rs2_val), 64'h77);
        chk("t4_s3_rs1", 64'(out_rs1_val), 64'hAA);
        cyc(1'b1, 5'd6, 5'd5, 32'hA005, 1'b0, 5'd0, '0, 1'b1, acc);
        chk("t4_xfer_acc", 64'(acc), 64'd1);
        chk("t4_xfer_rs2", 64'(out_rs2_val), 64'h77);
`ifdef OPFETCH_PERF_EN
        chk("t4_perf", 64'(perf_stall_cnt), 64'd3);
`endif
        idle(1'b1);
        chk("t4_next_valid", 64'(out_valid), 64'd1);
        chk("t4_next_payload", 64'(out_payload), 64'hA005);
        chk("t4_next_rs1", 64'(out_rs1_val), 64'h77);

        // Four back-to-back accepts, no bubbles.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 5'(i + 5), 5'(6 - i), 32'hC000 + 32'(i), 1'b0, 5'd0, '0, 1'b1, acc);
            chk("t5_acc", 64'(acc), 64'd1);
            if (i > 0) chk("t5_valid", 64'(out_valid), 64'd1);
        end
        idle(1'b1);
        chk("t5_last_valid", 64'(out_valid), 64'd1);
        chk("t5_last_payload", 64'(out_payload), 64'hC003);
        idle(1'b1);
        chk("t5_drained", 64'(out_valid), 64'd0);

        // Reset while holding an instruction.
        cyc(1'b1, 5'd5, 5'd6, 32'hA006, 1'b0, 5'd0, '0, 1'b1, acc);
        idle(1'b0);
        idle(1'b0);
        do_reset();
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_payload", 64'(out_payload), 64'd0);
        chk("t6_rs1", 64'(out_rs1_val), 64'd0);
`ifdef OPFETCH_PERF_EN
        chk("t6_perf", 64'(perf_stall_cnt), 64'd0);
`endif
        cyc(1'b1, 5'd5, 5'd6, 32'hA007, 1'b0, 5'd0, '0, 1'b1, acc);
        idle(1'b1);
        chk("t6_rs1", 64'(out_rs1_val), 64'hAA);
        chk("t6_rs2", 64'(out_rs2_val), 64'h77);
        idle(1'b1);

        // Mixed stalls, bypasses and live forwards.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, 32'hB000 + 32'(i), tbl[i].we,
                tbl[i].wn, tbl[i].wv, tbl[i].ordy, acc);
            chk($sformatf("tbl%0d_acc", i), 64'(acc), 64'(tbl[i].acc));
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ov));
        end
`ifdef OPFETCH_PERF_EN
        chk("tbl_perf", 64'(perf_stall_cnt), 64'd4);
`endif
        idle(1'b1);
        idle(1'b1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("out_count", 64'(n_out), 64'(n_acc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Requester-side front end of the register file: drives both read ports and the write port.
- Accepts one decoded instruction per cycle over a valid/ready handshake and issues its rs1/rs2 reads to the regfile, whose read data is registered (1-cycle latency).
- Presents resolved operand values to execute over a second valid/ready handshake, forwarding writeback data that the regfile read would miss.
- Holds operands stable across downstream stalls.

## Interface
Parameters:
- XLEN, 32, operand/data width
- PAYLOAD_W, 32, width of pass-through payload (instruction word, PC, etc.)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  upstream accept; transfer when in_valid && in_ready
- in_rs1  in  5  source register 1 name
- in_rs2  in  5  source register 2 name
- in_payload  in  PAYLOAD_W  carried unchanged to out_payload
- rf_r1_reg_name  out  5  regfile read port 1 name
- rf_r1_reg_val  in  XLEN  regfile read port 1 data, valid the cycle after the name
- rf_r2_reg_name  out  5  regfile read port 2 name
- rf_r2_reg_val  in  XLEN  regfile read port 2 data
- wb_enable  in  1  writeback request from the retire stage
- wb_reg_name  in  5  writeback destination
- wb_reg_val  in  XLEN  writeback data
- rf_w_enable  out  1  = wb_enable (combinational pass-through)
- rf_w_reg_name  out  5  = wb_reg_name
- rf_w_reg_val  out  XLEN  = wb_reg_val
- out_valid  out  1  operands valid
- out_ready  in  1  downstream accept
- out_rs1_val  out  XLEN  resolved operand 1
- out_rs2_val  out  XLEN  resolved operand 2
- out_payload  out  PAYLOAD_W  payload of the presented instruction

## Operation
- States:
  - EMPTY: no instruction held.
  - RF: operands come from rf_rN_reg_val this cycle.
  - HOLD: operands come from internal hold registers.
- out_valid = (state != EMPTY).
- in_ready = (state == EMPTY) || out_ready.
- accept = in_valid && in_ready.
- Read port drive:
  - rf_rN_reg_name = accept ? in_rsN : stored rsN.
  - stored rsN is cleared to 0 by reset.
- On accept:
  - Register rsN and payload.
  - Compute an issue-bypass per operand: wb_enable && wb_reg_name == in_rsN && in_rsN != 0.
  - If the bypass hits, latch wb_reg_val into byp_valN, because the regfile read of the same edge returns the pre-write value.
- Transitions:
  - EMPTY: accept → RF; otherwise stay.
  - RF or HOLD:
    - out_ready && accept → RF (new instruction).
    - out_ready && !accept → EMPTY.
    - !out_ready → HOLD.
- Operand resolution, in priority order:
  - rsN == 0 → 0 (wb to x0 never forwards).
  - Live wb hit (wb_enable && wb_reg_name == rsN) → wb_reg_val (combinational).
  - State RF: issue-bypass hit → byp_valN; otherwise rf_rN_reg_val.
  - State HOLD: hold_valN.
- Hold capture:
  - On RF→HOLD, hold_valN ← resolved value of that cycle.
  - While in HOLD, hold_valN ← wb_reg_val on every live wb hit.
- Write port is a pure pass-through; the block never originates writes.

## Timing
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_rsN_val = 0, out_payload = 0.
  - stored rsN and byp/hold registers = 0.
  - perf_stall_cnt = 0.
- Latency: accept in cycle N → out_valid in cycle N+1. Throughput is 1 instruction/cycle while out_ready = 1.
- out_rsN_val and out_payload are stable while out_valid && !out_ready, except for live wb forwarding of a newer writeback.
- Simultaneous out transfer and in accept: the new instruction is presented the next cycle, with no bubble.
- rst asserted mid-operation: the held instruction is discarded and all registers return to their reset values at the next edge. in_valid is ignored in the reset cycle.

## Configuration
- OPFETCH_PERF_EN defined:
  - Adds output port perf_stall_cnt (out, 32), counting cycles with out_valid && !out_ready.
  - The counter wraps 0xFFFFFFFF → 0 and is cleared by rst.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Regfile preloaded x5=0x11, x6=0x22; accept rs1=5, rs2=6 → next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22, payload matches.
- Accept rs1=5 with wb_enable, wb_reg_name=5, wb_reg_val=0xAA in the same cycle → out_rs1_val=0xAA (not 0x11).
- rs1=0 with wb to x0 value 0xFF in the issue cycle and the following cycle → out_rs1_val=0 in both cycles.
- out_ready=0 for 3 cycles after issue of rs2=6; wb x6=0x77 in the 2nd stall cycle → out_rs2_val is 0x22, then 0x77 from the wb cycle onward. in_ready=0 throughout the stall; perf_stall_cnt=3 with OPFETCH_PERF_EN.
- Back-to-back accepts of 4 instructions with out_ready=1 → 4 consecutive out_valid cycles in order, no bubbles.
- rst pulsed while in HOLD → next cycle out_valid=0, in_ready=1; a subsequent issue returns correct regfile values.
